// File: rtl/mod_cu_if.sv
// Control/status bundle between the modulo control unit and its datapath/requester.
interface mod_cu_if;
    logic        start;
    logic        less_than;
    logic        isAssgn;
    logic        isComp;
    logic        isSub;
    logic        assgn;
    logic        isDone;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] iter_cnt;

    // Requester/datapath side: drives start and the compare result, observes strobes.
    modport master (
        output start, less_than,
        input  isAssgn, isComp, isSub, assgn, isDone, busy, done, err, iter_cnt
    );

    // Control-unit side.
    modport slave (
        input  start, less_than,
        output isAssgn, isComp, isSub, assgn, isDone, busy, done, err, iter_cnt
    );
endinterface

// File: rtl/mod_cu.sv
// Moore control unit sequencing a repeated-subtract modulo datapath; MOD_CU_ITER_LIMIT_EN adds an iteration cap.
// Latency: FIN reached 4k+5 edges after start is sampled (k subtracts), 4k+4 on an iteration-limit abort.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module mod_cu #(
    parameter logic [15:0] ITER_MAX = 16'hFFFF
) (
    input  logic     CLK,
    input  logic     RST,
    mod_cu_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMP,
        ST_CHECK,
        ST_SUB,
        ST_ASGN,
        ST_DONE,
        ST_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_limit;
    logic [15:0] r_iter_cnt;
    logic        r_is_assgn;
    logic        r_is_comp;
    logic        r_is_sub;
    logic        r_assgn;
    logic        r_is_done;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

`ifdef MOD_CU_ITER_LIMIT_EN
    assign w_limit = (r_iter_cnt == ITER_MAX);
`else
    logic [15:0] w_unused_iter_max;
    assign w_unused_iter_max = ITER_MAX;
    assign w_limit           = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = bus.start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  w_next = ST_COMP;
            ST_COMP:  w_next = ST_CHECK;
            ST_CHECK: begin
                if (bus.less_than)
                    w_next = ST_DONE;
                else if (w_limit)
                    w_next = ST_FIN;
                else
                    w_next = ST_SUB;
            end
            ST_SUB:   w_next = ST_ASGN;
            ST_ASGN:  w_next = ST_COMP;
            ST_DONE:  w_next = ST_FIN;
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they always match the current state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_iter_cnt <= 16'd0;
            r_is_assgn <= 1'b0;
            r_is_comp  <= 1'b0;
            r_is_sub   <= 1'b0;
            r_assgn    <= 1'b0;
            r_is_done  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_is_assgn <= (w_next == ST_LOAD);
            r_is_comp  <= (w_next == ST_COMP);
            r_is_sub   <= (w_next == ST_SUB);
            r_assgn    <= (w_next == ST_ASGN);
            r_is_done  <= (w_next == ST_DONE);
            r_busy     <= (w_next != ST_IDLE);
            r_done     <= (w_next == ST_FIN);
`ifdef MOD_CU_ITER_LIMIT_EN
            r_err      <= (r_state == ST_CHECK) && (w_next == ST_FIN);
`else
            r_err      <= 1'b0;
`endif
            if (w_next == ST_LOAD)
                r_iter_cnt <= 16'd0;
            else if ((w_next == ST_SUB) && (r_iter_cnt != 16'hFFFF))
                r_iter_cnt <= r_iter_cnt + 16'd1;
        end
    end

    assign bus.isAssgn  = r_is_assgn;
    assign bus.isComp   = r_is_comp;
    assign bus.isSub    = r_is_sub;
    assign bus.assgn    = r_assgn;
    assign bus.isDone   = r_is_done;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_mod_cu.sv
// Self-checking bench for mod_cu with a behavioural modulo datapath and a completion scoreboard.
module tb_mod_cu;

`ifdef MOD_CU_ITER_LIMIT_EN
    localparam logic [15:0] TB_ITER_MAX = 16'd2;
    localparam bit          LIM_EN      = 1'b1;
`else
    localparam logic [15:0] TB_ITER_MAX = 16'hFFFF;
    localparam bit          LIM_EN      = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mod_cu_if bus ();

    mod_cu #(.ITER_MAX(TB_ITER_MAX)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Datapath driven by the strobes.
    logic [15:0] ain, bin, wres, wsub, result;
    always @(posedge CLK) begin
        if (bus.isAssgn) wres <= ain;
        if (bus.isComp)  bus.less_than <= (wres < bin);
        if (bus.isSub)   wsub <= wres - bin;
        if (bus.assgn)   wres <= wsub;
        if (bus.isDone)  result <= wres;
    end

    typedef struct {
        logic [15:0] result;
        int          iter;
        logic        err;
        int          fin_edge;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic exp_t model_op(input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [15:0] w;
        int          k;
        w = a;
        k = 0;
        e.result   = 16'd0;
        e.err      = 1'b0;
        e.iter     = 0;
        e.fin_edge = -1;
        for (int i = 0; i < 70000; i++) begin
            if (w < b) begin
                e.result   = w;
                e.iter     = k;
                e.fin_edge = 4 * k + 5;
                return e;
            end
            if (LIM_EN && (k == int'(TB_ITER_MAX))) begin
                e.err      = 1'b1;
                e.iter     = k;
                e.fin_edge = 4 * k + 4;
                return e;
            end
            w = w - b;
            k++;
        end
        return e;
    endfunction

    function automatic logic [4:0] strobes();
        return {bus.isAssgn, bus.isComp, bus.isSub, bus.assgn, bus.isDone};
    endfunction

    // Expected one-hot strobe pattern in the cycle after edge n (edge 1 samples start).
    function automatic logic [4:0] exp_strobe(input int n, input exp_t e);
        int k;
        k = e.iter;
        if (n == 1) return 5'b10000;
        if (n <= 4 * k + 1) begin
            case ((n - 2) % 4)
                0:       return 5'b01000;
                2:       return 5'b00100;
                3:       return 5'b00010;
                default: return 5'b00000;
            endcase
        end
        if (n == 4 * k + 2) return 5'b01000;
        if (n == 4 * k + 3) return 5'b00000;
        if (!e.err && (n == 4 * k + 4)) return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic logic [15:0] exp_iter(input int n, input exp_t e);
        if (n == 1) return 16'd0;
        if (n <= 4 * e.iter + 1) return 16'((n - 2) / 4 + (((n - 2) % 4) >= 2 ? 1 : 0));
        return 16'(e.iter);
    endfunction

    // One operation; restart_edge re-pulses start mid-op, abort_edge asserts RST, hold keeps start high.
    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input int restart_edge, input int abort_edge, input bit hold);
        exp_t e, got;
        bit   seen;
        e    = model_op(a, b);
        seen = 1'b0;
        ain  = a;
        bin  = b;
        bus.start = 1'b1;
        if (abort_edge == 0) sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        if (!hold) bus.start = 1'b0;
        for (int n = 1; (n <= e.fin_edge + 3) && !seen; n++) begin
            if (n > 1) @(negedge CLK);
            n_checks++;
            if (strobes() !== exp_strobe(n, e))
                $display("FAIL %s strobes edge %0d got=%b want=%b", nm, n, strobes(), exp_strobe(n, e));
            else n_pass++;
            n_checks++;
            if (bus.iter_cnt !== exp_iter(n, e))
                $display("FAIL %s iter_cnt edge %0d got=%0d want=%0d", nm, n, bus.iter_cnt, exp_iter(n, e));
            else n_pass++;
            n_checks++;
            if (bus.busy !== (n <= e.fin_edge))
                $display("FAIL %s busy edge %0d got=%b", nm, n, bus.busy);
            else n_pass++;
            n_checks++;
            if ((bus.done !== (n == e.fin_edge)) || (bus.err !== ((n == e.fin_edge) && e.err)))
                $display("FAIL %s done/err edge %0d got=%b/%b want=%b/%b", nm, n, bus.done, bus.err,
                         (n == e.fin_edge), ((n == e.fin_edge) && e.err));
            else n_pass++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL %s unexpected done edge %0d", nm, n);
                end else begin
                    got = sb.pop_front();
                    if ((n != got.fin_edge) || (bus.err !== got.err) ||
                        (bus.iter_cnt !== 16'(got.iter)) || (!got.err && (result !== got.result)))
                        $display("FAIL %s completion got edge=%0d err=%b iter=%0d res=%0d want edge=%0d err=%b iter=%0d res=%0d",
                                 nm, n, bus.err, bus.iter_cnt, result, got.fin_edge, got.err, got.iter, got.result);
                    else n_pass++;
                end
            end
            if (n == restart_edge) bus.start = 1'b1;
            if ((restart_edge > 0) && (n == restart_edge + 2)) bus.start = 1'b0;
            if (n == abort_edge) begin
                RST = 1'b1;
                @(posedge CLK);
                @(negedge CLK);
                RST = 1'b0;
                n_checks++;
                if ((bus.busy !== 1'b0) || (bus.iter_cnt !== 16'd0) || (bus.done !== 1'b0) ||
                    (bus.err !== 1'b0) || (strobes() !== 5'b00000))
                    $display("FAIL %s abort state busy=%b iter=%0d done=%b err=%b strobes=%b",
                             nm, bus.busy, bus.iter_cnt, bus.done, bus.err, strobes());
                else n_pass++;
                begin
                    int pulses;
                    pulses = 0;
                    for (int c = 0; c < 20; c++) begin
                        @(negedge CLK);
                        if ((bus.done === 1'b1) || (bus.err === 1'b1) || (bus.busy === 1'b1)) pulses++;
                    end
                    n_checks++;
                    if (pulses != 0) $display("FAIL %s activity after abort got=%0d want=0", nm, pulses);
                    else n_pass++;
                end
                return;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s timeout no done within %0d edges", nm, e.fin_edge + 3);
            sb.delete();
        end
        @(negedge CLK);
        n_checks++;
        if ((bus.busy !== 1'b0) || (bus.done !== 1'b0) || (bus.iter_cnt !== 16'(e.iter)))
            $display("FAIL %s idle after fin busy=%b done=%b iter=%0d want iter=%0d",
                     nm, bus.busy, bus.done, bus.iter_cnt, e.iter);
        else n_pass++;
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if ((bus.busy !== 1'b0) || (strobes() !== 5'b00000) || (bus.iter_cnt !== 16'd0) ||
            (bus.done !== 1'b0) || (bus.err !== 1'b0))
            $display("FAIL reset_state busy=%b strobes=%b iter=%0d done=%b err=%b",
                     bus.busy, strobes(), bus.iter_cnt, bus.done, bus.err);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if ((strobes() !== 5'b10000) || (bus.busy !== 1'b1))
            $display("FAIL reset_then_load strobes=%b busy=%b want 10000/1", strobes(), bus.busy);
        else n_pass++;
        bus.start = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if ((bus.busy !== 1'b0) || (bus.iter_cnt !== 16'd0))
            $display("FAIL reset_from_load busy=%b iter=%0d", bus.busy, bus.iter_cnt);
        else n_pass++;
    endtask

    task automatic test_normal();
        run_op("normal_10_3", 16'd10, 16'd3, 0, 0, 1'b0);
        run_op("exact_9_3",   16'd9,  16'd3, 0, 0, 1'b0);
        run_op("mod_15_4",    16'd15, 16'd4, 0, 0, 1'b0);
        run_op("mod_100_7",   16'd100, 16'd7, 0, 0, 1'b0);
    endtask

    task automatic test_zero_iter();
        run_op("zero_2_5", 16'd2, 16'd5, 0, 0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_op("busy_ignore", 16'd10, 16'd3, 4, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first",  16'd10, 16'd3, 0, 0, 1'b1);
        run_op("b2b_second", 16'd2,  16'd5, 0, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        run_op("mid_reset", 16'd10, 16'd3, 0, 9, 1'b0);
    endtask

    task automatic test_limit();
`ifdef MOD_CU_ITER_LIMIT_EN
        run_op("limit_7_0", 16'd7, 16'd0, 0, 0, 1'b0);
`else
        int dones;
        dones = 0;
        ain = 16'd7;
        bin = 16'd0;
        bus.start = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if ((bus.done === 1'b1) || (bus.err === 1'b1) || (bus.isDone === 1'b1)) dones++;
        end
        n_checks++;
        if ((dones != 0) || (bus.busy !== 1'b1))
            $display("FAIL nolimit_bin0 done/err pulses=%0d busy=%b want 0/1", dones, bus.busy);
        else n_pass++;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL nolimit_reset busy=%b want 0", bus.busy);
        else n_pass++;
`endif
    endtask

    initial begin
        RST = 1'b1;
        bus.start = 1'b0;
        ain = 16'd0;
        bin = 16'd0;
        test_reset();
        test_normal();
        test_zero_iter();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        test_limit();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
